// File: rtl/det_event_logger_pkg.sv
// Shared types and default sizes for the detection event logger.
package det_logger_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ARMED,
      DRAIN
   } logger_state_t;

   localparam int TS_W_DEF  = 16;
   localparam int DEPTH_DEF = 4;

endpackage

// File: rtl/det_event_logger_if.sv
// Valid/ready stream carrying logged timestamps from the logger to its reader.
interface det_logger_if
   import det_logger_pkg::*;
#(
   parameter int TS_W = TS_W_DEF
);

   logic            out_valid;
   logic            out_ready;
   logic [TS_W-1:0] out_ts;

   modport master (
      output out_valid,
      output out_ts,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_ts,
      output out_ready
   );

endinterface

// File: rtl/det_event_logger_sync_fifo.sv
// Small synchronous FIFO with registered pointers and an occupancy count.
// The head output reads as zero while the FIFO is empty.
module sync_fifo
   import det_logger_pkg::*;
#(
   parameter int WIDTH = TS_W_DEF,
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic [WIDTH-1:0]           data_i,
   output logic [WIDTH-1:0]           data_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
   logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             doPush;
   logic             doPop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign count_o = count_q;
   assign data_o  = empty_o ? '0 : mem_q[rdPtr_q];

   // A pop frees a slot in the same cycle, so a push into a full FIFO is allowed alongside it.
   always_comb begin
      doPop   = pop_i && !empty_o;
      doPush  = push_i && (!full_o || doPop);
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      count_d = count_q;
      if (doPush) begin
         wrPtr_d = wrPtr_q + PTR_W'(1);
      end
      if (doPop) begin
         rdPtr_d = rdPtr_q + PTR_W'(1);
      end
      if (doPush && !doPop) begin
         count_d = count_q + CNT_W'(1);
      end else if (doPop && !doPush) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   // Storage needs no reset because the head is masked whenever the FIFO is empty.
   always_ff @(posedge clk) begin
      if (doPush) begin
         mem_q[wrPtr_q] <= data_i;
      end
   end

   // Pointer and occupancy registers, flushed by the synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/det_event_logger.sv
// Timestamps detection pulses against an arm-relative cycle counter, buffers
// them in a FIFO for a valid/ready reader, and tracks a saturating detection
// count plus a sticky overflow flag.
module det_event_logger
   import det_logger_pkg::*;
#(
   parameter int TS_W  = TS_W_DEF,
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              det_i,
   input  logic              start_i,
   input  logic              stop_i,
   det_logger_if.master      out_if,
   output logic [TS_W-1:0]   det_count_o,
   output logic              overflow_o,
   output logic              busy_o
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   logger_state_t   state_q, state_d;
   logic [TS_W-1:0] tsCount_q, tsCount_d;
   logic [TS_W-1:0] detCount_q, detCount_d;
   logic            overflow_q, overflow_d;
   logic            capture;
   logic            fifoPush;
   logic            fifoPop;
   logic            fifoFull;
   logic            fifoEmpty;
   logic [CNT_W-1:0] fifoCount;

   assign fifoPop          = out_if.out_valid && out_if.out_ready;
   assign fifoPush         = capture && (!fifoFull || fifoPop);
   assign out_if.out_valid = !fifoEmpty;
   assign det_count_o      = detCount_q;
   assign overflow_o       = overflow_q;
   assign busy_o           = (state_q != IDLE);

   sync_fifo #(
      .WIDTH (TS_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (fifoPush),
      .pop_i   (fifoPop),
      .data_i  (tsCount_q),
      .data_o  (out_if.out_ts),
      .full_o  (fifoFull),
      .empty_o (fifoEmpty),
      .count_o (fifoCount)
   );

   // Next-state logic: arming clears the run statistics, capture only happens while
   // armed, and draining waits for the reader to empty the FIFO before going idle.
   always_comb begin
      state_d    = state_q;
      tsCount_d  = tsCount_q;
      detCount_d = detCount_q;
      overflow_d = overflow_q;
      capture    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d    = ARMED;
               tsCount_d  = '0;
               detCount_d = '0;
               overflow_d = 1'b0;
            end
         end
         ARMED: begin
            tsCount_d = tsCount_q + TS_W'(1);
            capture   = det_i;
            if (det_i) begin
               if (detCount_q != '1) begin
                  detCount_d = detCount_q + TS_W'(1);
               end
               if (fifoFull && !fifoPop) begin
                  overflow_d = 1'b1;
               end
            end
            if (stop_i) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (fifoCount == '0) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, timestamp and statistics registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= IDLE;
         tsCount_q  <= '0;
         detCount_q <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         tsCount_q  <= tsCount_d;
         detCount_q <= detCount_d;
         overflow_q <= overflow_d;
      end
   end

endmodule

// File: tb/tb_det_event_logger.sv
// Self-checking bench for det_event_logger: directed scenarios plus a randomized
// run compared against a queue-based behavioural model of the logger.
module tb_det_event_logger;
   import det_logger_pkg::*;

   localparam int W  = 16;
   localparam int WB = 4;
   localparam int D  = 4;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   logic          detA = 1'b0, startA = 1'b0, stopA = 1'b0;
   logic [W-1:0]  countA;
   logic          ovfA, busyA;

   logic          detB = 1'b0, startB = 1'b0, stopB = 1'b0;
   logic [WB-1:0] countB;
   logic          ovfB, busyB;

   det_logger_if #(.TS_W(W))  ifA ();
   det_logger_if #(.TS_W(WB)) ifB ();

   det_event_logger #(.TS_W(W), .DEPTH(D)) dutA (
      .clk         (clk),
      .reset       (reset),
      .det_i       (detA),
      .start_i     (startA),
      .stop_i      (stopA),
      .out_if      (ifA),
      .det_count_o (countA),
      .overflow_o  (ovfA),
      .busy_o      (busyA)
   );

   det_event_logger #(.TS_W(WB), .DEPTH(D)) dutB (
      .clk         (clk),
      .reset       (reset),
      .det_i       (detB),
      .start_i     (startB),
      .stop_i      (stopB),
      .out_if      (ifB),
      .det_count_o (countB),
      .overflow_o  (ovfB),
      .busy_o      (busyB)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Behavioural model of instance A: armed/draining flags, queue of timestamps.
   int mQ[$];
   bit mArmed = 0, mDrain = 0, mOvf = 0;
   int mTs = 0, mCount = 0;

   task automatic modelEdge();
      bit pop, cap;
      int capTs;
      if (!reset) begin
         mQ.delete();
         mArmed = 0; mDrain = 0; mOvf = 0; mTs = 0; mCount = 0;
         return;
      end
      pop   = (mQ.size() > 0) && ifA.out_ready;
      cap   = mArmed && detA;
      capTs = mTs;
      if (mArmed) begin
         mTs = (mTs + 1) % (1 << W);
         if (stopA) begin mArmed = 0; mDrain = 1; end
      end else if (mDrain) begin
         if (mQ.size() == 0) mDrain = 0;
      end else if (startA) begin
         mArmed = 1; mTs = 0; mCount = 0; mOvf = 0;
      end
      if (pop) void'(mQ.pop_front());
      if (cap) begin
         if (mCount < (1 << W) - 1) mCount++;
         if (mQ.size() < D) mQ.push_back(capTs);
         else mOvf = 1;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      modelEdge();
      #1;
   endtask

   task automatic armA();
      startA = 1'b1;
      tick();
      startA = 1'b0;
   endtask

   task automatic goIdle();
      stopA = 1'b1;
      tick();
      stopA = 1'b0;
      ifA.out_ready = 1'b1;
      for (int i = 0; i < 20 && busyA; i++) tick();
      checks++;
      if (busyA !== 1'b0) begin errors++; $display("[TB] FAIL idle_timeout: busy got %0b want 0", busyA); end
   endtask

   function automatic bit streamBit(int k);
      logic [11:0] pat;
      pat = 12'b1110_1101_1011;
      return pat[11 - (k % 12)];
   endfunction

   task automatic test_reset();
      reset = 1'b0;
      tick(); tick();
      checks += 5;
      if (ifA.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %0b want 0", ifA.out_valid); end
      if (ifA.out_ts !== '0) begin errors++; $display("[TB] FAIL reset_ts: got %0d want 0", ifA.out_ts); end
      if (countA !== '0) begin errors++; $display("[TB] FAIL reset_count: got %0d want 0", countA); end
      if (ovfA !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovf: got %0b want 0", ovfA); end
      if (busyA !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %0b want 0", busyA); end
      reset = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      int got[$];
      int exp[3] = '{2, 5, 9};
      int gv;
      ifA.out_ready = 1'b1;
      armA();
      for (int c = 0; c < 14; c++) begin
         detA = (c == 2 || c == 5 || c == 9);
         tick();
         detA = 1'b0;
         if (ifA.out_valid === 1'b1) got.push_back(int'(ifA.out_ts));
      end
      for (int i = 0; i < 3; i++) begin
         gv = (i < got.size()) ? got[i] : -1;
         checks++;
         if (gv != exp[i]) begin errors++; $display("[TB] FAIL basic_ts%0d: got %0d want %0d", i, gv, exp[i]); end
      end
      checks += 3;
      if (got.size() != 3) begin errors++; $display("[TB] FAIL basic_n: got %0d want 3", got.size()); end
      if (countA !== 16'd3) begin errors++; $display("[TB] FAIL basic_count: got %0d want 3", countA); end
      if (ovfA !== 1'b0) begin errors++; $display("[TB] FAIL basic_ovf: got %0b want 0", ovfA); end
      goIdle();
   endtask

   task automatic test_overflow();
      int got[$];
      ifA.out_ready = 1'b0;
      armA();
      for (int c = 0; c < 6; c++) begin detA = 1'b1; tick(); end
      detA = 1'b0;
      checks += 4;
      if (countA !== 16'd6) begin errors++; $display("[TB] FAIL ovf_count: got %0d want 6", countA); end
      if (ovfA !== 1'b1) begin errors++; $display("[TB] FAIL ovf_flag: got %0b want 1", ovfA); end
      if (ifA.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL ovf_valid: got %0b want 1", ifA.out_valid); end
      if (ifA.out_ts !== 16'd0) begin errors++; $display("[TB] FAIL ovf_head: got %0d want 0", ifA.out_ts); end
      ifA.out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (ifA.out_valid === 1'b1) got.push_back(int'(ifA.out_ts));
         tick();
      end
      checks++;
      if (got.size() != 4) begin errors++; $display("[TB] FAIL ovf_pops: got %0d want 4", got.size()); end
      for (int i = 0; i < got.size() && i < 4; i++) begin
         checks++;
         if (got[i] != i) begin errors++; $display("[TB] FAIL ovf_order%0d: got %0d want %0d", i, got[i], i); end
      end
      goIdle();
   endtask

   task automatic test_full_pushpop();
      int got[$];
      int exp[5] = '{0, 1, 2, 3, 7};
      int gv;
      ifA.out_ready = 1'b0;
      armA();
      for (int c = 0; c < 7; c++) begin detA = (c < 4); tick(); end
      detA = 1'b1;
      ifA.out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (ifA.out_valid === 1'b1) got.push_back(int'(ifA.out_ts));
         tick();
         detA = 1'b0;
      end
      for (int i = 0; i < 5; i++) begin
         gv = (i < got.size()) ? got[i] : -1;
         checks++;
         if (gv != exp[i]) begin errors++; $display("[TB] FAIL fullpp_ts%0d: got %0d want %0d", i, gv, exp[i]); end
      end
      checks += 2;
      if (got.size() != 5) begin errors++; $display("[TB] FAIL fullpp_n: got %0d want 5", got.size()); end
      if (ovfA !== 1'b0) begin errors++; $display("[TB] FAIL fullpp_ovf: got %0b want 0", ovfA); end
      goIdle();
   endtask

   task automatic test_stop_drain();
      int got[$];
      ifA.out_ready = 1'b0;
      armA();
      for (int c = 0; c < 4; c++) begin detA = (c == 1); tick(); end
      detA = 1'b1; stopA = 1'b1;
      tick();
      stopA = 1'b0;
      tick();
      detA = 1'b0;
      checks += 2;
      if (busyA !== 1'b1) begin errors++; $display("[TB] FAIL drain_busy: got %0b want 1", busyA); end
      if (countA !== 16'd2) begin errors++; $display("[TB] FAIL drain_count: got %0d want 2", countA); end
      ifA.out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (ifA.out_valid === 1'b1) got.push_back(int'(ifA.out_ts));
         tick();
         if (ifA.out_valid !== 1'b1) break;
      end
      checks += 3;
      if (got.size() != 2 || got[0] != 1 || got[1] != 4) begin
         errors++;
         $display("[TB] FAIL drain_entries: got n=%0d first=%0d want 1,4", got.size(), (got.size() > 0) ? got[0] : -1);
      end
      if (busyA !== 1'b1) begin errors++; $display("[TB] FAIL drain_busy_lastpop: got %0b want 1", busyA); end
      tick();
      if (busyA !== 1'b0) begin errors++; $display("[TB] FAIL drain_busy_after: got %0b want 0", busyA); end
   endtask

   task automatic test_reset_mid();
      ifA.out_ready = 1'b0;
      armA();
      detA = 1'b1; tick(); tick(); detA = 1'b0;
      checks++;
      if (ifA.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_pre_valid: got %0b want 1", ifA.out_valid); end
      reset = 1'b0;
      tick();
      checks += 4;
      if (ifA.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_valid: got %0b want 0", ifA.out_valid); end
      if (countA !== '0) begin errors++; $display("[TB] FAIL rstmid_count: got %0d want 0", countA); end
      if (busyA !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_busy: got %0b want 0", busyA); end
      if (ovfA !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_ovf: got %0b want 0", ovfA); end
      reset = 1'b1;
      tick();
   endtask

   // Detector stand-in: pulses in the cycle whose bit completes an overlapping 1101.
   task automatic test_reference();
      int got[$];
      int exp[$];
      bit d;
      for (int k = 3; k < 36; k++)
         if (streamBit(k-3) && streamBit(k-2) && !streamBit(k-1) && streamBit(k)) exp.push_back(k);
      ifA.out_ready = 1'b1;
      armA();
      for (int k = 0; k < 40; k++) begin
         d = (k >= 3 && k < 36) && streamBit(k-3) && streamBit(k-2) && !streamBit(k-1) && streamBit(k);
         detA = d;
         tick();
         detA = 1'b0;
         if (ifA.out_valid === 1'b1) got.push_back(int'(ifA.out_ts));
      end
      checks++;
      if (got.size() != exp.size()) begin errors++; $display("[TB] FAIL ref_n: got %0d want %0d", got.size(), exp.size()); end
      for (int i = 0; i < exp.size() && i < got.size(); i++) begin
         checks++;
         if (got[i] != exp[i]) begin errors++; $display("[TB] FAIL ref_ts%0d: got %0d want %0d", i, got[i], exp[i]); end
      end
      goIdle();
   endtask

   task automatic test_wrap_sat();
      int got[$];
      ifB.out_ready = 1'b1;
      startB = 1'b1; tick(); startB = 1'b0;
      for (int c = 0; c < 22; c++) begin
         detB = (c < 20);
         tick();
         detB = 1'b0;
         if (ifB.out_valid === 1'b1) got.push_back(int'(ifB.out_ts));
      end
      checks += 4;
      if (got.size() != 20) begin errors++; $display("[TB] FAIL wrap_n: got %0d want 20", got.size()); end
      if (got.size() > 17 && got[17] != 1) begin errors++; $display("[TB] FAIL wrap_ts17: got %0d want 1", got[17]); end
      if (countB !== 4'd15) begin errors++; $display("[TB] FAIL sat_count: got %0d want 15", countB); end
      if (ovfB !== 1'b0) begin errors++; $display("[TB] FAIL b2b_ovf: got %0b want 0", ovfB); end
      for (int i = 0; i < got.size(); i++) begin
         checks++;
         if (got[i] != i % 16) begin errors++; $display("[TB] FAIL wrap_ts%0d: got %0d want %0d", i, got[i], i % 16); end
      end
      stopB = 1'b1; tick(); stopB = 1'b0;
      tick(); tick();
      checks++;
      if (busyB !== 1'b0) begin errors++; $display("[TB] FAIL wrap_idle: got %0b want 0", busyB); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         detA          = ($urandom % 3 == 0);
         ifA.out_ready = ((i % 100) < 25) ? 1'b0 : ($urandom % 4 != 0);
         startA        = (i == 0) || ($urandom % 30 == 0);
         stopA         = ($urandom % 50 == 0);
         tick();
         checks += 4;
         if (ifA.out_valid !== (mQ.size() > 0)) begin errors++; $display("[TB] FAIL rnd_valid@%0d: got %0b want %0b", i, ifA.out_valid, mQ.size() > 0); end
         if (countA !== W'(mCount)) begin errors++; $display("[TB] FAIL rnd_count@%0d: got %0d want %0d", i, countA, mCount); end
         if (ovfA !== mOvf) begin errors++; $display("[TB] FAIL rnd_ovf@%0d: got %0b want %0b", i, ovfA, mOvf); end
         if (busyA !== (mArmed || mDrain)) begin errors++; $display("[TB] FAIL rnd_busy@%0d: got %0b want %0b", i, busyA, mArmed || mDrain); end
         if (mQ.size() > 0) begin
            checks++;
            if (ifA.out_ts !== W'(mQ[0])) begin errors++; $display("[TB] FAIL rnd_ts@%0d: got %0d want %0d", i, ifA.out_ts, mQ[0]); end
         end
      end
      detA = 1'b0; startA = 1'b0; stopA = 1'b0;
      goIdle();
   endtask

   initial begin
      ifA.out_ready = 1'b0;
      ifB.out_ready = 1'b1;
      test_reset();
      test_basic();
      test_overflow();
      test_full_pushpop();
      test_stop_drain();
      test_reset_mid();
      test_reference();
      test_wrap_sat();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
